// File: rtl/pipe_pkg.sv
// Shared constants for the elastic pipeline buffer chain.
package pipe_pkg;

    localparam int PIPE_MAX_STAGES = 8;
    localparam int PIPE_DATA_W     = 32;

    // Canonical NOP (addi x0,x0,0); only for benches and debug display, never injected.
    localparam logic [31:0] PIPE_NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_stage.sv
// One valid/data register pair of the chain: loads from upstream, holds, or is cleared by flush.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              load,
    input  logic              up_valid,
    input  logic [DATA_W-1:0] up_data,
    output logic              v,
    output logic [DATA_W-1:0] d,
    output logic              v_nxt
);

    assign v_nxt = flush ? 1'b0 : (load ? up_valid : v);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v <= 1'b0;
            d <= '0;
        end else begin
            v <= v_nxt;
            // Data only moves with a valid word so a bubble never overwrites held data.
            if (!flush && load && up_valid) begin
                d <= up_data;
            end
        end
    end

endmodule

// File: rtl/pipe_buffer_chain.sv
// N-stage elastic valid/ready register chain with bubble collapse, flush and occupancy.
// Define PIPE_BUFFER_PERF_EN to add the stall_cnt / flush_drop_cnt performance counters.
module pipe_buffer_chain
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int STAGES = 2,
    parameter int CNT_W  = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              flush,
    output logic [CNT_W-1:0]  occupancy
`ifdef PIPE_BUFFER_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_drop_cnt
`endif
);

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_nxt;
    logic [STAGES-1:0] rdy;
    logic [STAGES:0]   vin;
    logic [DATA_W-1:0] din [STAGES+1];
    logic [CNT_W-1:0]  occ_nxt;

    assign vin    = {v_q, in_valid};
    assign din[0] = in_data;

    // Stage k is ready unless it and every stage after it are full with the output stalled;
    // written unrolled so there is no combinational chain through a single vector.
    always_comb begin
        logic all_full;
        rdy = '0;
        for (int k = 0; k < STAGES; k++) begin
            all_full = 1'b1;
            for (int j = k; j < STAGES; j++) begin
                all_full = all_full & v_q[j];
            end
            rdy[k] = out_ready | ~all_full;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipe_stage #(.DATA_W(DATA_W)) u_stage (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .load     (rdy[k]),
            .up_valid (vin[k]),
            .up_data  (din[k]),
            .v        (v_q[k]),
            .d        (din[k+1]),
            .v_nxt    (v_nxt[k])
        );
    end

    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = v_q[STAGES-1] & ~flush;
    assign out_data  = din[STAGES];

    always_comb begin
        occ_nxt = '0;
        for (int k = 0; k < STAGES; k++) begin
            occ_nxt = occ_nxt + CNT_W'(v_nxt[k]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occupancy <= '0;
        end else begin
            occupancy <= occ_nxt;
        end
    end

`ifdef PIPE_BUFFER_PERF_EN
    logic [32:0] drop_sum;

    assign drop_sum = {1'b0, flush_drop_cnt} + 33'(occupancy);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt      <= '0;
            flush_drop_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flush) begin
                flush_drop_cnt <= drop_sum[32] ? '1 : drop_sum[31:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_buffer_chain.sv
// Bench for pipe_buffer_chain: vector table on a 2-stage chain, corner sequences and a
// randomized run against a queue-based reference model on a 4-stage chain.
module tb_pipe_buffer_chain;
    import pipe_pkg::*;

    localparam int S4 = 4;

    logic clk = 1'b0;
    logic reset;

    logic        iv2, or2, fl2, ir2, ov2;
    logic [31:0] id2, od2;
    logic [1:0]  occ2;

    logic        iv4, or4, fl4, ir4, ov4;
    logic [31:0] id4, od4;
    logic [2:0]  occ4;

`ifdef PIPE_BUFFER_PERF_EN
    logic [31:0] sc2, fd2, sc4, fd4;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_buffer_chain #(.DATA_W(32), .STAGES(2)) u_dut2 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (iv2),
        .in_data   (id2),
        .in_ready  (ir2),
        .out_valid (ov2),
        .out_data  (od2),
        .out_ready (or2),
        .flush     (fl2),
        .occupancy (occ2)
`ifdef PIPE_BUFFER_PERF_EN
        ,
        .stall_cnt      (sc2),
        .flush_drop_cnt (fd2)
`endif
    );

    pipe_buffer_chain #(.DATA_W(32), .STAGES(S4)) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (iv4),
        .in_data   (id4),
        .in_ready  (ir4),
        .out_valid (ov4),
        .out_data  (od4),
        .out_ready (or4),
        .flush     (fl4),
        .occupancy (occ4)
`ifdef PIPE_BUFFER_PERF_EN
        ,
        .stall_cnt      (sc4),
        .flush_drop_cnt (fd4)
`endif
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model: queue of words (front = oldest) tagged with their stage position.
    typedef struct {
        logic [31:0] data;
        int          pos;
    } ent_t;
    ent_t mq[$];

    task automatic model_step(input bit iv, input logic [31:0] d, input bit ordy, input bit fl,
                              output bit e_ir, output bit e_ov, output logic [31:0] e_od);
        bit mv[$];
        bit m;
        mv = {};
        // A word advances if it leaves via a consuming output, or the slot ahead is free/vacating.
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].pos == S4 - 1)                          m = ordy;
            else if (i > 0 && mq[i-1].pos == mq[i].pos + 1)   m = mv[i-1];
            else                                              m = 1'b1;
            mv.push_back(m);
        end
        e_ov = !fl && mq.size() > 0 && mq[0].pos == S4 - 1;
        e_od = e_ov ? mq[0].data : 32'h0;
        if (mq.size() == 0 || mq[mq.size()-1].pos != 0) e_ir = !fl;
        else                                             e_ir = !fl && mv[mq.size()-1];
        if (fl) begin
            mq.delete();
        end else begin
            for (int i = 0; i < mq.size(); i++) if (mv[i]) mq[i].pos++;
            if (mq.size() > 0 && mq[0].pos == S4) void'(mq.pop_front());
            if (iv && e_ir) mq.push_back('{d, 0});
        end
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        fl;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
        logic [1:0]  e_occ;
    } vec_t;
    vec_t tbl[23];

    task automatic drive4(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
        @(negedge clk);
        iv4 = iv; id4 = d; or4 = ordy; fl4 = fl;
        #1;
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit          e_ir, e_ov;
        logic [31:0] e_od;

        //          iv  data        ordy fl  ir ov  out_data    occ
        tbl[0]  = '{1, 32'h1,       1,   0,  1, 0,  32'h0,      1};
        tbl[1]  = '{1, 32'h2,       1,   0,  1, 0,  32'h0,      2};
        tbl[2]  = '{1, 32'h3,       1,   0,  1, 1,  32'h1,      2};
        tbl[3]  = '{1, 32'h4,       1,   0,  1, 1,  32'h2,      2};
        tbl[4]  = '{1, 32'h5,       1,   0,  1, 1,  32'h3,      2};
        tbl[5]  = '{0, 32'h0,       1,   0,  1, 1,  32'h4,      1};
        tbl[6]  = '{0, 32'h0,       1,   0,  1, 1,  32'h5,      0};
        tbl[7]  = '{1, 32'hA,       0,   0,  1, 0,  32'h0,      1};
        tbl[8]  = '{1, 32'hB,       0,   0,  1, 0,  32'h0,      2};
        tbl[9]  = '{1, 32'hC,       0,   0,  0, 1,  32'hA,      2};
        tbl[10] = '{0, 32'h0,       1,   0,  1, 1,  32'hA,      1};
        tbl[11] = '{0, 32'h0,       1,   0,  1, 1,  32'hB,      0};
        tbl[12] = '{1, 32'h10,      0,   0,  1, 0,  32'h0,      1};
        tbl[13] = '{1, 32'h11,      0,   0,  1, 0,  32'h0,      2};
        tbl[14] = '{1, 32'h12,      0,   1,  0, 0,  32'h0,      0};
        tbl[15] = '{1, 32'h13,      1,   0,  1, 0,  32'h0,      1};
        tbl[16] = '{0, 32'h0,       1,   0,  1, 0,  32'h0,      1};
        tbl[17] = '{0, 32'h0,       1,   0,  1, 1,  32'h13,     0};
        tbl[18] = '{1, 32'h20,      0,   0,  1, 0,  32'h0,      1};
        tbl[19] = '{1, 32'h21,      0,   0,  1, 0,  32'h0,      2};
        tbl[20] = '{1, 32'h22,      1,   0,  1, 1,  32'h20,     2};
        tbl[21] = '{0, 32'h0,       1,   0,  1, 1,  32'h21,     1};
        tbl[22] = '{0, 32'h0,       1,   0,  1, 1,  32'h22,     0};

        // Reset held with in_valid asserted.
        reset = 1'b0;
        iv2 = 1'b1; id2 = 32'hDEAD_BEEF; or2 = 1'b0; fl2 = 1'b0;
        iv4 = 1'b1; id4 = 32'hDEAD_BEEF; or4 = 1'b0; fl4 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_valid2", 32'(ov2), 32'h0);
        chk("rst_occ2", 32'(occ2), 32'h0);
        chk("rst_out_data2", od2, 32'h0);
        chk("rst_out_valid4", 32'(ov4), 32'h0);
        chk("rst_occ4", 32'(occ4), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        iv2 = 1'b0; iv4 = 1'b0; id4 = PIPE_NOP;
        #1;
        chk("rst_rel_in_ready2", 32'(ir2), 32'h1);
        chk("rst_rel_in_ready4", 32'(ir4), 32'h1);

        // Vector table on the 2-stage chain.
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            iv2 = tbl[i].iv; id2 = tbl[i].d; or2 = tbl[i].ordy; fl2 = tbl[i].fl;
            #1;
            chk($sformatf("vec%0d_in_ready", i), 32'(ir2), 32'(tbl[i].e_ir));
            chk($sformatf("vec%0d_out_valid", i), 32'(ov2), 32'(tbl[i].e_ov));
            if (tbl[i].e_ov) chk($sformatf("vec%0d_out_data", i), od2, tbl[i].e_od);
            edge_wait();
            chk($sformatf("vec%0d_occupancy", i), 32'(occ2), 32'(tbl[i].e_occ));
        end
        @(negedge clk);
        iv2 = 1'b0; or2 = 1'b1; fl2 = 1'b0;

        // Bubble collapse on the 4-stage chain: a lone word travels to the end under stall.
        drive4(1'b1, 32'hC0DE, 1'b0, 1'b0);
        chk("bub_in_ready_first", 32'(ir4), 32'h1);
        edge_wait();
        for (int i = 0; i < 3; i++) begin
            drive4(1'b0, PIPE_NOP, 1'b0, 1'b0);
            edge_wait();
        end
        chk("bub_out_valid", 32'(ov4), 32'h1);
        chk("bub_out_data", od4, 32'hC0DE);
        chk("bub_occ1", 32'(occ4), 32'h1);
        for (int i = 0; i < 3; i++) begin
            drive4(1'b1, 32'(i + 1), 1'b0, 1'b0);
            chk($sformatf("bub_push%0d_in_ready", i), 32'(ir4), 32'h1);
            edge_wait();
        end
        chk("bub_occ_full", 32'(occ4), 32'h4);
        drive4(1'b1, 32'h99, 1'b0, 1'b0);
        chk("full_in_ready", 32'(ir4), 32'h0);
        edge_wait();
        chk("full_hold_occ", 32'(occ4), 32'h4);

        // Drain one word, then flush three with in_valid high.
        drive4(1'b0, PIPE_NOP, 1'b1, 1'b0);
        chk("drain_out_data", od4, 32'hC0DE);
        edge_wait();
        chk("drain_occ3", 32'(occ4), 32'h3);
        drive4(1'b1, 32'hBAD, 1'b0, 1'b1);
        chk("flush_in_ready", 32'(ir4), 32'h0);
        chk("flush_out_valid", 32'(ov4), 32'h0);
        edge_wait();
        chk("flush_occ", 32'(occ4), 32'h0);
        for (int i = 0; i < 6; i++) begin
            drive4(1'b0, PIPE_NOP, 1'b1, 1'b0);
            chk($sformatf("post_flush%0d_out_valid", i), 32'(ov4), 32'h0);
            edge_wait();
        end

        // Async reset dropped between edges with the chain full and stalled.
        for (int i = 0; i < 4; i++) begin
            drive4(1'b1, 32'h40 + 32'(i), 1'b0, 1'b0);
            edge_wait();
        end
        chk("stall_full_occ", 32'(occ4), 32'h4);
        chk("stall_out_valid", 32'(ov4), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(ov4), 32'h0);
        chk("async_rst_occ", 32'(occ4), 32'h0);
        chk("async_rst_out_data", od4, 32'h0);
`ifdef PIPE_BUFFER_PERF_EN
        chk("async_rst_stall_cnt", sc4, 32'h0);
        chk("async_rst_flush_drop_cnt", fd4, 32'h0);
`endif
        @(negedge clk);
        reset = 1'b1;
        iv4 = 1'b0;
        #1;
        chk("async_rel_in_ready", 32'(ir4), 32'h1);

        // Randomized traffic against the reference model.
        mq.delete();
        for (int c = 0; c < 600; c++) begin
            logic        r_iv, r_or, r_fl;
            logic [31:0] r_d;
            r_iv = ($urandom_range(0, 3) != 0);
            r_or = ($urandom_range(0, 9) < 6);
            r_fl = ($urandom_range(0, 24) == 0);
            r_d  = $urandom;
            drive4(r_iv, r_d, r_or, r_fl);
            model_step(r_iv, r_d, r_or, r_fl, e_ir, e_ov, e_od);
            chk("rnd_in_ready", 32'(ir4), 32'(e_ir));
            chk("rnd_out_valid", 32'(ov4), 32'(e_ov));
            if (e_ov) chk("rnd_out_data", od4, e_od);
            edge_wait();
            chk("rnd_occupancy", 32'(occ4), 32'(mq.size()));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_buffer_chain.md
Name: pipe_buffer_chain

Overview:
- Parametrised successor to the fixed IF/ID-style enable buffers: an N-stage elastic pipeline register chain carrying DATA_W-bit words with per-stage valid bits.
- Uses a valid/ready handshake, bubble collapsing, global flush and an occupancy count.
- Sits between instruction fetch and decode, and between later stages, replacing hand-chained enable buffers.

Parameters:
- DATA_W, 32, width of each stored word (instruction or datapath word)
- STAGES, 2, number of register stages; legal range 1..8
- CNT_W, $clog2(STAGES+1), occupancy counter width (derived; do not override)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream presents a word
- in_data  input  DATA_W  upstream word
- in_ready  output  1  chain accepts in_data this cycle
- out_valid  output  1  last stage holds a valid word
- out_data  output  DATA_W  last-stage word
- out_ready  input  1  downstream consumes the word this cycle
- flush  input  1  discard all held words (branch/redirect)
- occupancy  output  CNT_W  number of valid stages

Behaviour:
- State: per stage k (0 = input side, STAGES-1 = output side), registers v[k] and d[k].
- Reset (reset=0, asynchronous): all v[k]=0, all d[k]=0.
  - Resulting outputs: out_valid=0, out_data=0, occupancy=0, in_ready=1 when flush=0.
- Ready chain (combinational):
  - r[STAGES] = out_ready.
  - r[k] = !v[k] | r[k+1].
  - in_ready = r[0] & !flush.
- Stage advance on each rising edge, with flush=0:
  - Stage k loads from stage k-1 (or from the input for k=0) when r[k]=1.
  - v[k] <= v[k-1] (in_valid for k=0).
  - d[k] <= the upstream data, but only when the upstream valid is 1. Otherwise d[k] holds.
  - When r[k]=0, stage k holds both v and d.
- Bubble collapse: an empty stage always accepts, so a stalled output never blocks upstream stages that have holes ahead of them.
- Latency: a word accepted at edge t appears with out_valid=1 after edge t+STAGES-1 (STAGES cycles of register delay), provided there are no stalls.
- Throughput: 1 word/cycle with out_ready held at 1.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - Both may occur in the same cycle, including when the chain is full.
- out_valid = v[STAGES-1] & !flush; out_data = d[STAGES-1].
- Flush:
  - On the next edge all v[k] clear; d[k] holds.
  - During the flush cycle no input is accepted (in_ready=0) and no output is presented (out_valid=0).
  - Flush overrides stalls.
- Full chain (all v=1) with out_ready=0: in_ready=0 and all stages hold.
- Empty chain: out_valid=0; in_ready=1.
- occupancy: registered popcount of v, updated on the same edge as v.
- Reset asserted mid-operation: immediate clear, independent of clk and flush.
- Data is never reordered, duplicated or dropped, except by flush or reset.

Optional Feature:
- Macro: PIPE_BUFFER_PERF_EN.
- When defined, two extra output ports are added:
  - stall_cnt (32 bits): counts cycles with out_valid=1 and out_ready=0.
  - flush_drop_cnt (32 bits): adds occupancy on every flush edge.
  - Both counters saturate at all-ones and reset to 0.
- When undefined: the ports and counters do not exist, and the core behaviour is identical.

Decomposition:
- Shared package pipe_pkg:
  - PIPE_MAX_STAGES = 8
  - default DATA_W constant
  - NOP instruction word constant (32'h00000013), for benches and debug display only; the chain itself does not inject it.
- Sub-module pipe_stage: one v/d register pair with load/hold/flush logic.
  - pipe_buffer_chain instantiates STAGES copies in a generate loop and builds the ready chain and occupancy around them.

Test Plan:
- Reset/idle: reset=0 while in_valid=1 -> out_valid=0, occupancy=0, out_data=0. Release reset -> in_ready=1.
- Streaming: STAGES=2, out_ready=1, push 32'h00000001..32'h00000005 on consecutive cycles -> out_data delivers the same sequence in order, first word 2 cycles after its acceptance, one word per cycle.
- Back-pressure: fill with 32'hA, 32'hB, hold out_ready=0 -> occupancy=2, in_ready=0. Raise out_ready -> 32'hA then 32'hB, no loss.
- Bubble collapse: STAGES=4, a single word 32'hC0DE plus out_ready=0 -> it reaches the last stage; the next 3 pushes are accepted and occupancy=4.
- Flush: occupancy=3, assert flush for 1 cycle with in_valid=1 -> in_ready=0 and out_valid=0 that cycle, occupancy=0 next cycle, flushed words never appear at the output.
- Async reset mid-stall: full chain, drop reset between edges -> out_valid falls before the next edge. With PIPE_BUFFER_PERF_EN defined: stall_cnt and flush_drop_cnt read 0.
